// File: rtl/wb_pkg.sv
// Shared widths, the buffered MCU result entry and the write-source encoding
// used by the write-back port arbiter and its result FIFO.
package wb_pkg;

  localparam int DATA_W   = 22;
  localparam int REG_W    = 4;
  localparam int NUM_REGS = 2 ** REG_W;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Which source owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_PIPE   = 2'd1,
    SRC_FIFO   = 2'd2,
    SRC_BYPASS = 2'd3
  } wb_src_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Small circular buffer of MCU results; the occupancy count tells full from
// empty, pointers wrap modulo DEPTH (power of two).
module wb_result_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the WB stage and buffered MCU
// results. Optional same-cycle MCU bypass when WB_BYPASS_EN is defined.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pipe_valid_in,
  input  logic [REG_W-1:0]    pipe_reg_in,
  input  logic [DATA_W-1:0]   pipe_data_in,
  input  logic                mc_valid_in,
  input  logic [REG_W-1:0]    mc_reg_in,
  input  logic [DATA_W-1:0]   mc_data_in,
  output logic                mc_ready_out,
  output logic                stall_out,
  output logic                rf_we_out,
  output logic [REG_W-1:0]    rf_wa_out,
  output logic [DATA_W-1:0]   rf_wd_out,
  output logic [NUM_REGS-1:0] pending_regs_out
);

  // MCU handshake: a result transfers on a cycle where mc_valid_in and
  // mc_ready_out are both high; the MCU holds reg/data stable until then.
  // mc_ready_out is built only from registered full/pending state.

  localparam int SC_W = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

  wb_entry_t             head;
  wb_entry_t             push_entry;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic                  ready;
  logic                  force_fifo;
  logic                  stall;
  wb_src_t               src;
  logic [NUM_REGS-1:0]   pending;
  logic [NUM_REGS-1:0]   pending_nxt;
  logic [SC_W-1:0]       starve_cnt;
  logic                  we;
  logic [REG_W-1:0]      wa;
  logic [DATA_W-1:0]     wd;

  assign push_entry = '{rd: mc_reg_in, data: mc_data_in};

  wb_result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign ready = !fifo_full && !pending[mc_reg_in];

  // A WB write to a register the MCU still owes must wait for the older
  // MCU result, otherwise the stale value would land last.
  assign force_fifo = !fifo_empty &&
                      ((starve_cnt == STARVE_LIM) ||
                       (pipe_valid_in && pending[pipe_reg_in]));

  always_comb begin
    src   = SRC_NONE;
    stall = 1'b0;
    if (force_fifo) begin
      src   = SRC_FIFO;
      stall = pipe_valid_in;
    end else if (pipe_valid_in) begin
      src = SRC_PIPE;
    end else if (!fifo_empty) begin
      src = SRC_FIFO;
    end
`ifdef WB_BYPASS_EN
    else if (mc_valid_in && !pending[mc_reg_in]) begin
      src = SRC_BYPASS;
    end
`endif
  end

  assign pop  = (src == SRC_FIFO);
  assign push = mc_valid_in && ready && (src != SRC_BYPASS);

  always_comb begin
    we = (src != SRC_NONE);
    wa = pipe_reg_in;
    wd = pipe_data_in;
    case (src)
      SRC_FIFO: begin
        wa = head.rd;
        wd = head.data;
      end
      SRC_BYPASS: begin
        wa = mc_reg_in;
        wd = mc_data_in;
      end
      default: begin
        wa = pipe_reg_in;
        wd = pipe_data_in;
      end
    endcase
  end

  // Clear before set: a same-cycle pop and push never target one register.
  always_comb begin
    pending_nxt = pending;
    if (pop) begin
      pending_nxt[head.rd] = 1'b0;
    end
    if (push) begin
      pending_nxt[mc_reg_in] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      starve_cnt <= '0;
    end else begin
      pending <= pending_nxt;
      if (fifo_empty || pop) begin
        starve_cnt <= '0;
      end else if (starve_cnt != STARVE_LIM) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  // Outputs read as zero for the whole time reset is held.
  assign mc_ready_out     = rst_n && ready;
  assign stall_out        = rst_n && stall;
  assign rf_we_out        = rst_n && we;
  assign rf_wa_out        = rst_n ? wa : '0;
  assign rf_wd_out        = rst_n ? wd : '0;
  assign pending_regs_out = rst_n ? pending : '0;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset forcing, MCU latency, starvation,
// WAW ordering, FIFO full/wrap, per-register exclusivity and mid-burst reset.
module tb_wb_port_arbiter;
  import wb_pkg::*;

  logic                clk;
  logic                rst_n;
  logic                pipe_valid_in;
  logic [REG_W-1:0]    pipe_reg_in;
  logic [DATA_W-1:0]   pipe_data_in;
  logic                mc_valid_in;
  logic [REG_W-1:0]    mc_reg_in;
  logic [DATA_W-1:0]   mc_data_in;
  logic                mc_ready_out;
  logic                stall_out;
  logic                rf_we_out;
  logic [REG_W-1:0]    rf_wa_out;
  logic [DATA_W-1:0]   rf_wd_out;
  logic [NUM_REGS-1:0] pending_regs_out;

  int n_cmp;
  int n_err;

  wb_port_arbiter #(
    .FIFO_DEPTH (4),
    .STARVE_MAX (8)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pipe_valid_in    (pipe_valid_in),
    .pipe_reg_in      (pipe_reg_in),
    .pipe_data_in     (pipe_data_in),
    .mc_valid_in      (mc_valid_in),
    .mc_reg_in        (mc_reg_in),
    .mc_data_in       (mc_data_in),
    .mc_ready_out     (mc_ready_out),
    .stall_out        (stall_out),
    .rf_we_out        (rf_we_out),
    .rf_wa_out        (rf_wa_out),
    .rf_wd_out        (rf_wd_out),
    .pending_regs_out (pending_regs_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge; inputs are driven here and
  // outputs are sampled 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pipe(input logic v, input logic [REG_W-1:0] r, input logic [DATA_W-1:0] d);
    pipe_valid_in = v;
    pipe_reg_in   = r;
    pipe_data_in  = d;
  endtask

  task automatic mc(input logic v, input logic [REG_W-1:0] r, input logic [DATA_W-1:0] d);
    mc_valid_in = v;
    mc_reg_in   = r;
    mc_data_in  = d;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    pipe(1'b1, 4'd3, 22'h3);
    mc(1'b1, 4'd6, 22'h6);
    #2;
    chk("rst_we", 32'(rf_we_out), 32'h0);
    chk("rst_wa", 32'(rf_wa_out), 32'h0);
    chk("rst_wd", 32'(rf_wd_out), 32'h0);
    chk("rst_stall", 32'(stall_out), 32'h0);
    chk("rst_ready", 32'(mc_ready_out), 32'h0);
    chk("rst_pending", 32'(pending_regs_out), 32'h0);
    pipe(1'b0, 4'd0, 22'h0);
    mc(1'b0, 4'd0, 22'h0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // MCU result r5 with the pipe idle.
    mc(1'b1, 4'd5, 22'h00ABC);
    #1;
    chk("a_ready", 32'(mc_ready_out), 32'h1);
`ifdef WB_BYPASS_EN
    chk("a_byp_we", 32'(rf_we_out), 32'h1);
    chk("a_byp_wa", 32'(rf_wa_out), 32'h5);
    chk("a_byp_wd", 32'(rf_wd_out), 32'h00ABC);
    cyc();
    mc(1'b0, 4'd0, 22'h0);
    #1;
    chk("a_byp_pend", 32'(pending_regs_out), 32'h0);
    chk("a_byp_we2", 32'(rf_we_out), 32'h0);
`else
    chk("a_we0", 32'(rf_we_out), 32'h0);
    cyc();
    mc(1'b0, 4'd0, 22'h0);
    #1;
    chk("a_pend_set", 32'(pending_regs_out), 32'h0020);
    chk("a_we", 32'(rf_we_out), 32'h1);
    chk("a_wa", 32'(rf_wa_out), 32'h5);
    chk("a_wd", 32'(rf_wd_out), 32'h00ABC);
    cyc();
    #1;
    chk("a_pend_clr", 32'(pending_regs_out), 32'h0);
    chk("a_idle", 32'(rf_we_out), 32'h0);
`endif
    cyc();

    // Starvation: pipe writes every cycle while r3 waits in the FIFO.
    pipe(1'b1, 4'd1, 22'h111);
    mc(1'b1, 4'd3, 22'h333);
    #1;
    chk("b_push_ready", 32'(mc_ready_out), 32'h1);
    chk("b_pipe_wa", 32'(rf_wa_out), 32'h1);
    cyc();
    mc(1'b0, 4'd0, 22'h0);
    chk("b_pend", 32'(pending_regs_out), 32'h0008);
    for (int i = 0; i < 8; i++) begin
      pipe_data_in = 22'(32'h200 + i);
      #1;
      chk($sformatf("b_pipe_win%0d", i), {31'h0, stall_out, rf_wa_out, rf_wd_out} >> 0,
          {31'h0, 1'b0, 4'd1, 22'(32'h200 + i)});
      cyc();
    end
    pipe_data_in = 22'h2FF;
    #1;
    chk("b_force_stall", 32'(stall_out), 32'h1);
    chk("b_force_wa", 32'(rf_wa_out), 32'h3);
    chk("b_force_wd", 32'(rf_wd_out), 32'h333);
    cyc();
    chk("b_after_stall", 32'(stall_out), 32'h0);
    chk("b_after_wa", 32'(rf_wa_out), 32'h1);
    chk("b_after_wd", 32'(rf_wd_out), 32'h2FF);
    chk("b_after_pend", 32'(pending_regs_out), 32'h0);
    pipe(1'b0, 4'd0, 22'h0);
    cyc();

    // WAW: FIFO holds r7=1, pipe then asks for r7=2.
    pipe(1'b1, 4'd1, 22'h55);
    mc(1'b1, 4'd7, 22'h1);
    cyc();
    mc(1'b0, 4'd0, 22'h0);
    pipe(1'b1, 4'd7, 22'h2);
    #1;
    chk("c_stall", 32'(stall_out), 32'h1);
    chk("c_wa1", 32'(rf_wa_out), 32'h7);
    chk("c_wd1", 32'(rf_wd_out), 32'h1);
    cyc();
    chk("c_nostall", 32'(stall_out), 32'h0);
    chk("c_we2", 32'(rf_we_out), 32'h1);
    chk("c_wd2", 32'(rf_wd_out), 32'h2);
    pipe(1'b0, 4'd0, 22'h0);
    cyc();

    // Fill r1..r4 with the pipe busy on r0, then offer r5 into a full FIFO.
    pipe(1'b1, 4'd0, 22'h0);
    for (int i = 1; i <= 4; i++) begin
      mc(1'b1, 4'(i), 22'(32'h100 + i));
      #1;
      chk($sformatf("d_ready%0d", i), 32'(mc_ready_out), 32'h1);
      cyc();
    end
    mc(1'b1, 4'd5, 22'h105);
    #1;
    chk("d_full_ready", 32'(mc_ready_out), 32'h0);
    chk("d_full_pend", 32'(pending_regs_out), 32'h001E);
    cyc();
    pipe(1'b0, 4'd0, 22'h0);
    #1;
    chk("d_pop1_wa", 32'(rf_wa_out), 32'h1);
    chk("d_pop1_ready", 32'(mc_ready_out), 32'h0);
    cyc();
    chk("d_pop2_ready", 32'(mc_ready_out), 32'h1);
    chk("d_pop2_wa", 32'(rf_wa_out), 32'h2);
    cyc();
    mc(1'b0, 4'd0, 22'h0);
    #1;
    chk("d_pop3_wa", 32'(rf_wa_out), 32'h3);
    cyc();
    chk("d_pop4_wa", 32'(rf_wa_out), 32'h4);
    chk("d_pop4_wd", 32'(rf_wd_out), 32'h104);
    cyc();
    chk("d_pop5_wa", 32'(rf_wa_out), 32'h5);
    chk("d_pop5_wd", 32'(rf_wd_out), 32'h105);
    cyc();
    chk("d_empty_we", 32'(rf_we_out), 32'h0);
    chk("d_empty_pend", 32'(pending_regs_out), 32'h0);

    // One outstanding result per register.
    pipe(1'b1, 4'd0, 22'h0);
    mc(1'b1, 4'd2, 22'hA2);
    cyc();
    mc(1'b1, 4'd2, 22'hB2);
    #1;
    chk("e_busy_ready", 32'(mc_ready_out), 32'h0);
    cyc();
    pipe(1'b0, 4'd0, 22'h0);
    #1;
    chk("e_pop_wd", 32'(rf_wd_out), 32'hA2);
    chk("e_pop_ready", 32'(mc_ready_out), 32'h0);
    cyc();
    pipe(1'b1, 4'd0, 22'h0);
    #1;
    chk("e_accept_ready", 32'(mc_ready_out), 32'h1);
    cyc();
    mc(1'b0, 4'd0, 22'h0);
    pipe(1'b0, 4'd0, 22'h0);
    #1;
    chk("e_second_wa", 32'(rf_wa_out), 32'h2);
    chk("e_second_wd", 32'(rf_wd_out), 32'hB2);
    cyc();

    // Reset in the middle of a burst of three buffered results.
    pipe(1'b1, 4'd0, 22'h0);
    for (int i = 1; i <= 3; i++) begin
      mc(1'b1, 4'(i + 8), 22'(32'h300 + i));
      cyc();
    end
    mc(1'b0, 4'd0, 22'h0);
    chk("f_pend", 32'(pending_regs_out), 32'h0E00);
    #2;
    rst_n = 1'b0;
    #1;
    chk("f_rst_we", 32'(rf_we_out), 32'h0);
    chk("f_rst_pend", 32'(pending_regs_out), 32'h0);
    chk("f_rst_wa", 32'(rf_wa_out), 32'h0);
    cyc();
    pipe(1'b0, 4'd0, 22'h0);
    rst_n = 1'b1;
    #1;
    chk("f_post_pend", 32'(pending_regs_out), 32'h0);
    chk("f_post_ready", 32'(mc_ready_out), 32'h1);
    chk("f_post_we", 32'(rf_we_out), 32'h0);
    cyc();
    chk("f_post_we2", 32'(rf_we_out), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
